// File: rtl/fifo_pkg.sv
// fifo_pkg: read/write-side shared FSM encodings and Gray code helpers.
package fifo_pkg;
  localparam int GW = 9;
  typedef enum logic [1:0] {IDLE = 2'b00, ACTIVE = 2'b01, EMPTY = 2'b10} rd_state_e;
  function automatic logic [GW-1:0] bin2gray(input logic [GW-1:0] b);
    return b ^ (b >> 1);
  endfunction
  function automatic logic [GW-1:0] gray2bin(input logic [GW-1:0] g);
    logic [GW-1:0] b;
    b = g;
    for (int i = GW - 2; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction
endpackage

// File: rtl/fifo_ptr_sync.sv
// fifo_ptr_sync: two-flop synchronizer for a Gray pointer crossing into this clock.
module fifo_ptr_sync #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  logic [W-1:0] q1_q;
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      q1_q <= '0;
      q <= '0;
    end else begin
      q1_q <= d;
      q <= q1_q;
    end
endmodule

// File: rtl/fifo_read_logic.sv
// fifo_read_logic: async FIFO read-side pointer, empty flag and read strobe.
// FIFO_RD_ALMOST_EMPTY_EN adds the registered ralmost_empty output.
module fifo_read_logic
  import fifo_pkg::*;
#(
  parameter int PTR_SZ = 2,
  parameter int AE_THRESH = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              rinc,
  input  logic [PTR_SZ:0]   waddr_gray,
  output logic              rempty,
  output logic              read_en,
  output logic [PTR_SZ-1:0] raddr,
  output logic [PTR_SZ:0]   raddr_gray
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  ,
  output logic              ralmost_empty
`endif
);
  localparam int W = PTR_SZ + 1;
  logic [W-1:0] rbin_q, rbin_d, rgray_d, wq2;
  logic rempty_d;
  rd_state_e state_q, state_d;
  fifo_ptr_sync #(.W(W)) u_sync (.clk(clk), .rst(rst), .d(waddr_gray), .q(wq2));
  always_comb begin
    rbin_d = rbin_q + W'(rinc & ~rempty);
    rgray_d = W'(bin2gray(GW'(rbin_d)));
    rempty_d = rgray_d == wq2;
    state_d = state_q == IDLE ? EMPTY : rempty_d ? EMPTY : ACTIVE;
  end
  assign read_en = rinc & ~rempty & (state_q == ACTIVE);
  assign raddr = rbin_q[PTR_SZ-1:0];
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      rbin_q <= '0;
      raddr_gray <= '0;
      rempty <= 1'b1;
      state_q <= IDLE;
    end else begin
      rbin_q <= rbin_d;
      raddr_gray <= rgray_d;
      rempty <= rempty_d;
      state_q <= state_d;
    end
`ifdef FIFO_RD_ALMOST_EMPTY_EN
  logic [W-1:0] occ;
  assign occ = W'(gray2bin(GW'(wq2))) - rbin_d;
  always_ff @(posedge clk or negedge rst)
    if (!rst) ralmost_empty <= 1'b1;
    else ralmost_empty <= occ <= W'(AE_THRESH);
`endif
endmodule

// File: doc/fifo_read_logic.md
FIFO_READ_LOGIC -- requirements
Module: fifo_read_logic

Interface
REQ-001 SHALL have parameter PTR_SZ, default 2, entry index width in bits; FIFO depth = 2**PTR_SZ; legal range 2..8.
REQ-002 SHALL have parameter AE_THRESH, default 1, almost-empty threshold in entries; used only under FIFO_RD_ALMOST_EMPTY_EN.
REQ-003 SHALL have port clk, input, 1, read-domain clock.
REQ-004 SHALL have port rst, input, 1, reset, asynchronous, active-low.
REQ-005 SHALL have port rinc, input, 1, read request from the consumer.
REQ-006 SHALL have port waddr_gray, input, PTR_SZ+1, unsynchronized Gray write pointer from the write domain.
REQ-007 SHALL have port rempty, output, 1, registered FIFO-empty flag.
REQ-008 SHALL have port read_en, output, 1, RAM read strobe for this cycle.
REQ-009 SHALL have port raddr, output, PTR_SZ, RAM read index.
REQ-010 SHALL have port raddr_gray, output, PTR_SZ+1, registered Gray read pointer toward the write domain.
REQ-011 SHALL have port ralmost_empty, output, 1, registered almost-empty flag; present only under FIFO_RD_ALMOST_EMPTY_EN.

Function
REQ-012 SHALL keep a binary read pointer rbin of PTR_SZ+1 bits: rbin_next = rbin + (rinc & ~rempty); wraps modulo 2**(PTR_SZ+1).
REQ-013 SHALL register rbin <= rbin_next and raddr_gray <= (rbin_next >> 1) ^ rbin_next at each posedge clk.
REQ-014 SHALL drive raddr = rbin[PTR_SZ-1:0] directly from the register, with no added latency.
REQ-015 SHALL pass waddr_gray through two flops (wq2) before any use; no combinational path from waddr_gray to outputs.
REQ-016 SHALL register rempty <= (Gray(rbin_next) == wq2); a write becomes visible as rempty=0 on the third clk edge after waddr_gray changes.
REQ-017 SHALL ignore rinc while rempty=1: pointer held, read_en=0, no underflow.
REQ-018 SHALL implement FSM IDLE/ACTIVE/EMPTY: IDLE after reset -> EMPTY next edge; EMPTY -> ACTIVE when rempty_next=0; ACTIVE -> EMPTY when rempty_next=1; otherwise hold.
REQ-019 SHALL drive read_en = rinc & ~rempty & (state == ACTIVE), combinationally.
REQ-020 SHALL handle the last-entry read: rinc with one entry left advances rbin and asserts rempty on the same edge.
REQ-021 SHALL handle simultaneous read and write pointer change normally: rempty uses the new rbin_next against the old wq2, which errs toward empty (safe).
REQ-022 SHALL wrap raddr from 2**PTR_SZ-1 to 0, toggling the MSB of rbin.

Reset
REQ-023 SHALL asynchronously set, on rst=0: rbin=0, raddr=0, raddr_gray=0, both wq2 flop stages=0, rempty=1, ralmost_empty=1, state=IDLE.
REQ-024 SHALL release reset synchronously to clk; a reset mid-operation discards all pointer state, and the write side is reset together with it.

Configuration
REQ-025 SHALL, with FIFO_RD_ALMOST_EMPTY_EN defined, convert wq2 from Gray to binary (wbin_s), compute occ = wbin_s - rbin_next modulo 2**(PTR_SZ+1), and register ralmost_empty <= (occ <= AE_THRESH).
REQ-026 SHALL, without FIFO_RD_ALMOST_EMPTY_EN, omit the ralmost_empty port and the Gray-to-binary logic; all other behaviour is identical.

Structure
REQ-027 SHALL take the FSM state encodings (IDLE=2'b00, ACTIVE=2'b01, EMPTY=2'b10) and the bin2gray/gray2bin functions from shared package fifo_pkg, which the write side also uses.
REQ-028 SHALL instantiate sub-module fifo_ptr_sync (parameter W, 2-flop synchronizer, async active-low reset to 0) for wq2.

Verification (PTR_SZ=2, AE_THRESH=1)
REQ-029 SHALL check reset: after rst released, rempty=1, raddr=0, raddr_gray=3'b000, read_en=0 with rinc=1 held high.
REQ-030 SHALL check sync latency: waddr_gray 000->001 -> rempty falls on the 3rd clk edge; rinc=1 then gives read_en=1, raddr 0->1, raddr_gray=001, rempty=1 on the same edge.
REQ-031 SHALL check fill and drain: waddr_gray=110 (4 writes), rinc held -> raddr 0,1,2,3 then rempty=1, raddr_gray=110, and 4 read_en pulses total.
REQ-032 SHALL check wrap: 8 write/read pairs -> rbin passes 111 -> 000, raddr_gray sequence 000,001,011,010,110,111,101,100,000.
REQ-033 SHALL check underflow: rinc=1 for 5 cycles while empty -> rbin unchanged, read_en=0.
REQ-034 SHALL check the macro build: 2 entries present -> ralmost_empty=0; after one read -> ralmost_empty=1, rempty=0.
